// File: rtl/switch_debounce_pulse_pkg.sv
// Shared definitions for the switch debounce block.
// Holds the per-channel FSM state encoding and the counter-width helper.
package switch_debounce_pulse_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } deb_state_t;

    // Width of a counter holding 0..cnt_max, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned cnt_max);
        return (cnt_max < 32'd1) ? 32'd1 : 32'($clog2(cnt_max + 32'd1));
    endfunction

endpackage

// File: rtl/switch_debounce_pulse_channel.sv
// One debounce channel: 2-flop synchronizer, stability counter/FSM and edge pulses.
// Ports:
//   clk    in  1  board clock
//   rst_n  in  1  asynchronous active-low reset
//   raw    in  1  raw bouncing switch input, asynchronous to clk
//   level  out 1  debounced level (registered)
//   rise   out 1  one-cycle pulse on debounced 0->1 (registered)
//   fall   out 1  one-cycle pulse on debounced 1->0 (registered); tied to 0 unless
//                 DEBOUNCE_FALL_PULSE_EN is defined
module switch_debounce_pulse_channel
    import switch_debounce_pulse_pkg::*;
#(
    parameter int unsigned CNT_MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = cnt_width(CNT_MAX);

    logic             sync1;
    logic             s;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             settle_c;

    // Two back-to-back flops, nothing in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    // Level accepts s on this edge: counter reached CNT_MAX with s still differing,
    // or immediately when no stable time is required.
    assign settle_c = (s != level) &&
                      (((state == ST_CHECK) && (cnt == CNT_W'(CNT_MAX))) ||
                       ((state == ST_STABLE) && (CNT_MAX == 32'd0)));

    // Stability FSM; entering CHECK already counts the first differing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STABLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            case (state)
                ST_STABLE: begin
                    if (settle_c) begin
                        level <= s;
                    end else if (s != level) begin
                        state <= ST_CHECK;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (s == level) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (settle_c) begin
                        level <= s;
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Pulses coincide with the first cycle of the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise <= 1'b0;
        end else begin
            rise <= settle_c & s;
        end
    end

`ifdef DEBOUNCE_FALL_PULSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall <= 1'b0;
        end else begin
            fall <= settle_c & ~s;
        end
    end
`else
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce_pulse.sv
// Debounces WIDTH mechanical switches, giving a clean level plus edge pulses per channel.
// Optional feature macro: DEBOUNCE_FALL_PULSE_EN enables sw_fall pulses (else sw_fall = 0).
// Ports:
//   clk       in  1      board clock
//   rst_n     in  1      asynchronous active-low reset
//   sw_raw    in  WIDTH  raw bouncing switch inputs
//   sw_level  out WIDTH  debounced levels
//   sw_rise   out WIDTH  one-cycle pulses on debounced 0->1
//   sw_fall   out WIDTH  one-cycle pulses on debounced 1->0
module switch_debounce_pulse
    import switch_debounce_pulse_pkg::*;
#(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned DEBOUNCE_MS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int unsigned CNT_MAX = CLK_HZ / 32'd1000 * DEBOUNCE_MS - 32'd1;

    // Independent channels, one per switch.
    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_ch
        switch_debounce_pulse_channel #(
            .CNT_MAX (CNT_MAX)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (sw_raw[g]),
            .level (sw_level[g]),
            .rise  (sw_rise[g]),
            .fall  (sw_fall[g])
        );
    end

endmodule

// File: tb/tb_switch_debounce_pulse.sv
// Directed bench for switch_debounce_pulse with CNT_MAX=3 (6-edge settle latency).
module tb_switch_debounce_pulse;

`ifdef DEBOUNCE_FALL_PULSE_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw_raw = 3'b000;
    logic [2:0] sw_level;
    logic [2:0] sw_rise;
    logic [2:0] sw_fall;

    int tests = 0;
    int fails = 0;

    switch_debounce_pulse #(
        .WIDTH       (3),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_raw   (sw_raw),
        .sw_level (sw_level),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first_hi;
        int pulses;
        int hi_cnt;

        // 1: reset with all switches high
        rst_n  = 1'b0;
        sw_raw = 3'b111;
        steps(3);
        check("reset_level", sw_level, 3'b000);
        check("reset_rise", sw_rise, 3'b000);
        check("reset_fall", sw_fall, 3'b000);
        rst_n = 1'b1;
        steps(5);
        check("rel_level_e5", sw_level, 3'b000);
        step();
        check("rel_level_e6", sw_level, 3'b111);
        check("rel_rise_e6", sw_rise, 3'b111);
        check("rel_fall_e6", sw_fall, 3'b000);
        step();
        check("rel_rise_e7", sw_rise, 3'b000);
        check("rel_level_e7", sw_level, 3'b111);

        // Return all switches low
        sw_raw = 3'b000;
        steps(5);
        check("low_level_e5", sw_level, 3'b111);
        step();
        check("low_level_e6", sw_level, 3'b000);
        check("low_fall_e6", sw_fall, FALL_EN ? 3'b111 : 3'b000);
        check("low_rise_e6", sw_rise, 3'b000);
        step();
        check("low_fall_e7", sw_fall, 3'b000);

        // 2: clean press on bit 0
        sw_raw = 3'b001;
        steps(5);
        check("press_level_e5", sw_level, 3'b000);
        step();
        check("press_level_e6", sw_level, 3'b001);
        check("press_rise_e6", sw_rise, 3'b001);
        step();
        check("press_rise_e7", sw_rise, 3'b000);
        check("press_level_e7", sw_level, 3'b001);

        // 3: bounce on bit 1 (1,0,1,0 then hold 1 from step 4)
        first_hi = -1;
        pulses   = 0;
        for (int i = 0; i < 16; i++) begin
            sw_raw[1] = (i < 4) ? ((i % 2) == 0) : 1'b1;
            step();
            if (sw_level[1] && first_hi < 0) first_hi = i;
            if (sw_rise[1]) pulses++;
        end
        check_int("bounce_settle_step", first_hi, 9);
        check_int("bounce_rise_count", pulses, 1);
        check("bounce_level", sw_level, 3'b011);

        // 4: 3-cycle glitch on bit 2
        hi_cnt = 0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            sw_raw[2] = (i < 3);
            step();
            if (sw_level[2]) hi_cnt++;
            if (sw_rise[2]) pulses++;
        end
        check_int("glitch_level_hi", hi_cnt, 0);
        check_int("glitch_rise_count", pulses, 0);
        check("glitch_level", sw_level, 3'b011);

        // 5: release bit 0
        sw_raw[0] = 1'b0;
        steps(5);
        check("release_level_e5", sw_level, 3'b011);
        step();
        check("release_level_e6", sw_level, 3'b010);
        check("release_fall_e6", sw_fall, FALL_EN ? 3'b001 : 3'b000);
        check("release_rise_e6", sw_rise, 3'b000);
        step();
        check("release_fall_e7", sw_fall, 3'b000);

        // 6: reset in the middle of a press count
        sw_raw[0] = 1'b1;
        steps(3);
        rst_n = 1'b0;
        #1;
        check("midrst_level", sw_level, 3'b000);
        check("midrst_rise", sw_rise, 3'b000);
        check("midrst_fall", sw_fall, 3'b000);
        steps(2);
        rst_n = 1'b1;
        steps(5);
        check("midrst_level_e5", sw_level, 3'b000);
        step();
        check("midrst_level_e6", sw_level, 3'b011);
        check("midrst_rise_e6", sw_rise, 3'b011);
        step();
        check("midrst_rise_e7", sw_rise, 3'b000);
        check("midrst_fall_e7", sw_fall, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
